// File: rtl/fp_op_sequencer.sv
`timescale 1ns/1ps
// Purpose : sequences one FP add/sub/mul/div at a time through the shared calculator datapath.
// Latency : accept -> CLEAR (1) -> RUN (ADD_LAT / MUL_LAT / until calc_finish) -> DONE; 2+LAT cycles for fixed ops.
// Backpres: req_ready only in IDLE; DONE holds the response stable until rsp_ready.
// Optional: define FPSEQ_DIV_TIMEOUT_EN to abort a divide after DIV_TIMEOUT RUN cycles with a qNaN and rsp_err=1.
module fp_op_sequencer #(
    parameter int ADD_LAT     = 1,
    parameter int MUL_LAT     = 2,
    parameter int TAG_W       = 4,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [31:0]      calc_a,
    output logic [31:0]      calc_b,
    output logic [1:0]       calc_op,
    output logic             calc_en,
    output logic             calc_clr_n,
    input  logic [31:0]      calc_result,
    input  logic             calc_finish,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int              CNT_W    = 16;
    localparam logic [1:0]      OP_MUL   = 2'b10;
    localparam logic [1:0]      OP_DIV   = 2'b11;
    localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    // Latencies below 1 would make the completion compare unreachable.
    if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_TIMEOUT < 1) begin : g_param_check
        $error("fp_op_sequencer: ADD_LAT, MUL_LAT and DIV_TIMEOUT must be >= 1");
    end

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [31:0]        a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt;
    logic               done_now;

`ifdef FPSEQ_DIV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
    logic timeout_now;
`endif

    // The calculator sees the latched operands for the whole operation.
    assign calc_a  = a_q;
    assign calc_b  = b_q;
    assign calc_op = op_q;

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        calc_en    = 1'b0;
        calc_clr_n = 1'b1;
        busy       = 1'b1;
        done_now   = 1'b0;
`ifdef FPSEQ_DIV_TIMEOUT_EN
        timeout_now = 1'b0;
`endif
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = CLEAR;
            end
            CLEAR: begin
                calc_clr_n = 1'b0;
                state_nxt  = RUN;
            end
            RUN: begin
                calc_en = 1'b1;
                case (op_q)
                    OP_DIV: begin
                        if (calc_finish) begin
                            done_now = 1'b1;
                        end
`ifdef FPSEQ_DIV_TIMEOUT_EN
                        else if (cnt == DIV_LAST) begin
                            done_now    = 1'b1;
                            timeout_now = 1'b1;
                        end
`endif
                    end
                    OP_MUL:  done_now = (cnt == MUL_LAST);
                    default: done_now = (cnt == ADD_LAST);
                endcase
                if (done_now) state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, RUN cycle counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            tag_q    <= '0;
            cnt      <= '0;
            rsp_data <= 32'h0;
            rsp_tag  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q  <= req_op;
                a_q   <= req_a;
                b_q   <= req_b;
                tag_q <= req_tag;
            end
            if (state == CLEAR)    cnt <= '0;
            else if (state == RUN) cnt <= cnt + 1'b1;
            if (done_now) begin
`ifdef FPSEQ_DIV_TIMEOUT_EN
                rsp_data <= timeout_now ? QNAN : calc_result;
`else
                rsp_data <= calc_result;
`endif
                rsp_tag  <= tag_q;
            end
        end
    end

`ifdef FPSEQ_DIV_TIMEOUT_EN
    // Error flag travels with the captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rsp_err <= 1'b0;
        else if (done_now) rsp_err <= timeout_now;
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         op_count <= 16'h0;
        else if (state == DONE && rsp_ready) op_count <= op_count + 16'h1;
    end

endmodule

// File: tb/tb_fp_op_sequencer.sv
`timescale 1ns/1ps
// Directed bench for fp_op_sequencer: hand-computed vectors, immediate assertions.
// The calculator is modelled as a lookup table of the few operand pairs used.
// Built with default latencies (ADD_LAT=1, MUL_LAT=2) and DIV_TIMEOUT=8.
module tb_fp_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic [3:0]  req_tag = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic [31:0] calc_a, calc_b;
    logic [1:0]  calc_op;
    logic        calc_en, calc_clr_n;
    logic [31:0] calc_result;
    logic        calc_finish = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    int n_chk  = 0;
    int n_fail = 0;
    int lat, en_cyc, clr_cyc;
    logic rdy_seen, ops_bad;

    fp_op_sequencer #(.ADD_LAT(1), .MUL_LAT(2), .TAG_W(4), .DIV_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_en(calc_en),
        .calc_clr_n(calc_clr_n), .calc_result(calc_result), .calc_finish(calc_finish),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Calculator stand-in: returns the known result only for the exact operand/op pairs.
    always_comb begin
        calc_result = 32'hBAD0_BAD0;
        case (calc_op)
            2'b00: if (calc_a == 32'h3F80_0000 && calc_b == 32'h4000_0000) calc_result = 32'h4040_0000;
            2'b01: if (calc_a == 32'h4040_0000 && calc_b == 32'h3F80_0000) calc_result = 32'h4000_0000;
            2'b10: if (calc_a == 32'h4000_0000 && calc_b == 32'h4040_0000) calc_result = 32'h40C0_0000;
            2'b11: if (calc_a == 32'h40C0_0000 && calc_b == 32'h4000_0000) calc_result = 32'h4040_0000;
            default: calc_result = 32'hBAD0_BAD0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then sample once per cycle until rsp_valid or the budget runs out.
    // fin_at != 0 raises calc_finish during the fin_at-th RUN cycle.
    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input int fin_at, input bit keep_vld);
        bit stop;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        step();
        if (!keep_vld) req_valid = 1'b0;
        lat = 1; en_cyc = 0; clr_cyc = 0; rdy_seen = 1'b0; ops_bad = 1'b0; stop = 1'b0;
        while (!stop) begin
            if (!calc_clr_n) clr_cyc++;
            if (req_ready)   rdy_seen = 1'b1;
            if (calc_en) begin
                en_cyc++;
                if (calc_a !== a || calc_b !== b || calc_op !== op) ops_bad = 1'b1;
                calc_finish = (fin_at != 0 && en_cyc == fin_at);
            end else begin
                calc_finish = 1'b0;
            end
            if (rsp_valid || lat >= 200) stop = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        calc_finish = 1'b0;
        chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'h1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", {28'b0, rsp_tag}, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_calc_a", calc_a, 32'h0);
        chk("rst_calc_b", calc_b, 32'h0);
        chk("rst_calc_op", {30'b0, calc_op}, 32'h0);
        chk("rst_calc_en", {31'b0, calc_en}, 32'h0);
        chk("rst_calc_clr_n", {31'b0, calc_clr_n}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_op_count", {16'b0, op_count}, 32'h0);
        rst_n = 1'b1;
        step();

        // Add 1.0 + 2.0 = 3.0, tag 3
        run_req(2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd3, 0, 1'b0);
        chk("add_latency", lat, 32'd3);
        chk("add_clr_cycles", clr_cyc, 32'd1);
        chk("add_en_cycles", en_cyc, 32'd1);
        chk("add_ready_low", {31'b0, rdy_seen}, 32'h0);
        chk("add_operands", {31'b0, ops_bad}, 32'h0);
        chk("add_data", rsp_data, 32'h4040_0000);
        chk("add_tag", {28'b0, rsp_tag}, 32'd3);
        chk("add_err", {31'b0, rsp_err}, 32'h0);
        step();
        chk("add_op_count", {16'b0, op_count}, 32'd1);
        chk("add_ready_back", {31'b0, req_ready}, 32'h1);

        // Mul 2.0 * 3.0 = 6.0, tag 5
        run_req(2'b10, 32'h4000_0000, 32'h4040_0000, 4'd5, 0, 1'b0);
        chk("mul_latency", lat, 32'd4);
        chk("mul_en_cycles", en_cyc, 32'd2);
        chk("mul_operands", {31'b0, ops_bad}, 32'h0);
        chk("mul_data", rsp_data, 32'h40C0_0000);
        chk("mul_tag", {28'b0, rsp_tag}, 32'd5);
        step();
        chk("mul_op_count", {16'b0, op_count}, 32'd2);

        // Div 6.0 / 2.0 = 3.0, finish in the 11th RUN cycle
        run_req(2'b11, 32'h40C0_0000, 32'h4000_0000, 4'd6, 11, 1'b0);
        chk("div_en_cycles", en_cyc, 32'd11);
        chk("div_latency", lat, 32'd13);
        chk("div_data", rsp_data, 32'h4040_0000);
        chk("div_err", {31'b0, rsp_err}, 32'h0);
        step();
        chk("div_op_count", {16'b0, op_count}, 32'd3);

        // Sub 3.0 - 1.0 = 2.0 with rsp_ready low and req_valid held high
        rsp_ready = 1'b0;
        run_req(2'b01, 32'h4040_0000, 32'h3F80_0000, 4'd7, 0, 1'b1);
        chk("sub_latency", lat, 32'd3);
        chk("sub_ready_low", {31'b0, rdy_seen}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sub_hold_valid", {31'b0, rsp_valid}, 32'h1);
            chk("sub_hold_data", rsp_data, 32'h4000_0000);
            chk("sub_hold_tag", {28'b0, rsp_tag}, 32'd7);
            chk("sub_hold_ready", {31'b0, req_ready}, 32'h0);
        end
        chk("sub_hold_count", {16'b0, op_count}, 32'd3);
        // Next request (add, tag 9) waits on req_valid while the response is released
        req_op = 2'b00; req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_tag = 4'd9;
        rsp_ready = 1'b1;
        step();
        chk("sub_op_count", {16'b0, op_count}, 32'd4);
        chk("next_ready", {31'b0, req_ready}, 32'h1);
        step();
        req_valid = 1'b0;
        chk("next_accepted", {31'b0, busy}, 32'h1);
        chk("next_clear", {31'b0, calc_clr_n}, 32'h0);
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        chk("next_valid", {31'b0, rsp_valid}, 32'h1);
        chk("next_data", rsp_data, 32'h4040_0000);
        chk("next_tag", {28'b0, rsp_tag}, 32'd9);
        step();
        chk("next_op_count", {16'b0, op_count}, 32'd5);

        // Async reset in the middle of a divide
        req_op = 2'b11; req_a = 32'h40C0_0000; req_b = 32'h4000_0000; req_tag = 4'd2;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("abort_in_run", {31'b0, calc_en}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_calc_en", {31'b0, calc_en}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("abort_op_count", {16'b0, op_count}, 32'h0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'h1);
        chk("abort_calc_a", calc_a, 32'h0);
        #3 rst_n = 1'b1;
        step();
        run_req(2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd1, 0, 1'b0);
        chk("post_rst_latency", lat, 32'd3);
        chk("post_rst_data", rsp_data, 32'h4040_0000);
        chk("post_rst_tag", {28'b0, rsp_tag}, 32'd1);
        step();
        chk("post_rst_op_count", {16'b0, op_count}, 32'd1);

`ifdef FPSEQ_DIV_TIMEOUT_EN
        // Divide with no finish: times out after 8 RUN cycles
        run_req(2'b11, 32'h40C0_0000, 32'h4000_0000, 4'd4, 0, 1'b0);
        chk("tmo_en_cycles", en_cyc, 32'd8);
        chk("tmo_latency", lat, 32'd10);
        chk("tmo_data", rsp_data, 32'h7FC0_0000);
        chk("tmo_err", {31'b0, rsp_err}, 32'h1);
        chk("tmo_tag", {28'b0, rsp_tag}, 32'd4);
        step();
        chk("tmo_op_count", {16'b0, op_count}, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
Request/response controller that sequences single FP operations (add, sub, mul, div) through the shared floating-point calculator datapath. It accepts one request at a time over a valid/ready handshake and latches the operands. It then drives the calculator's operand, op and enable lines, waits the op-specific latency or the divider's finish flag, and returns the captured result over a valid/ready response handshake. It sits between the system bus/command logic and the calculator instance.

Parameters:
ADD_LAT, 1, RUN cycles before add/sub result is sampled (min 1)
MUL_LAT, 2, RUN cycles before multiply result is sampled (min 1)
TAG_W, 4, width of request tag echoed on the response
DIV_TIMEOUT, 64, max RUN cycles waiting for divide finish (used only with optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  2  00 add, 01 sub, 10 mul, 11 div
req_a  input  32  operand A (IEEE-754 single)
req_b  input  32  operand B
req_tag  input  TAG_W  requester tag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  result
rsp_tag  output  TAG_W  tag of the completed request
rsp_err  output  1  divide timeout (0 unless optional feature enabled)
calc_a  output  32  to calculator inA
calc_b  output  32  to calculator inB
calc_op  output  2  to calculator op
calc_en  output  1  to calculator en
calc_clr_n  output  1  to calculator rst_n (divider clear, active low)
calc_result  input  32  calculator out
calc_finish  input  1  calculator finish (divider done)
busy  output  1  state != IDLE
op_count  output  16  completed responses, wraps 0xFFFF->0

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low. Reset puts the FSM in IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, calc_a/b=0, calc_op=0, calc_en=0, calc_clr_n=1, busy=0, op_count=0.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid&&req_ready at a clk edge. On acceptance, latch op/a/b/tag into registers and go to CLEAR.
  - CLEAR, one cycle: calc_en=0, calc_clr_n=0. Go to RUN with cnt=0.
  - RUN: calc_en=1, calc_clr_n=1. calc_a/calc_b/calc_op come from the latched registers and are stable for the whole operation. cnt increments each RUN cycle.
    - add/sub completes when cnt==ADD_LAT-1.
    - mul completes when cnt==MUL_LAT-1.
    - div completes on the first RUN cycle with calc_finish=1.
    - On completion, sample calc_result into rsp_data and the latched tag into rsp_tag, then go to DONE.
  - DONE: calc_en=0, rsp_valid=1, and rsp_data/rsp_tag/rsp_err are held stable. On rsp_valid&&rsp_ready, increment op_count and go to IDLE.
- Outputs in other states: calc_en=0 outside RUN. calc_clr_n=0 only in CLEAR.
- Latency: a request accepted at edge T0 gives CLEAR in cycle T0+1 and RUN from T0+2. With add/sub and ADD_LAT=1, rsp_valid is high from T0+3. Total is 2 + LAT cycles for fixed ops.
- req_ready is 0 in CLEAR/RUN/DONE, so req_valid is ignored while busy. A response accepted at edge T gives req_ready=1 in cycle T+1. No back-to-back overlap.
- rsp_ready held low leaves DONE indefinitely with the response unchanged. rsp_ready while rsp_valid=0 has no effect.
- calc_finish outside RUN, or during a non-div op, is ignored.
- Asserting rst_n mid-operation aborts immediately with no response: calc_en=0 and all outputs take their reset values.
- rsp_err=0 for every response unless the optional feature is enabled.

Optional Feature:
- Macro: FPSEQ_DIV_TIMEOUT_EN.
- Defined: in RUN for div, if cnt reaches DIV_TIMEOUT-1 without calc_finish, complete with rsp_data=32'h7FC00000 (qNaN) and rsp_err=1. That response still counts in op_count.
- Undefined: divide waits on calc_finish forever, no timeout counter logic is built, and rsp_err is tied 0.

Test Plan:
- Reset, then add 0x3F800000 + 0x40000000, tag 3, with the calc model returning 0x40400000 combinationally -> req_ready drops next cycle, calc_clr_n low one cycle, rsp_valid exactly 3 cycles after accept with rsp_data=0x40400000, rsp_tag=3, op_count=1.
- Mul 0x40000000 * 0x40400000, MUL_LAT=2 -> calc_en high exactly 2 cycles, rsp_valid 4 cycles after accept, rsp_data=0x40C00000.
- Div 0x40C00000 / 0x40000000 with calc_finish raised 10 cycles into RUN -> calc_en high 10 cycles plus the finish cycle, rsp_data=0x40400000, rsp_err=0.
- Sub completes with rsp_ready held low 5 cycles while req_valid stays high -> response stable, req_ready=0 throughout. The next request is accepted the cycle after the response handshake.
- rst_n pulsed low during a div RUN -> calc_en=0 and busy=0 asynchronously, no rsp_valid, op_count=0. A later add completes normally.
- With FPSEQ_DIV_TIMEOUT_EN, DIV_TIMEOUT=8, calc_finish never set -> rsp_valid after 8 RUN cycles, rsp_data=0x7FC00000, rsp_err=1.
